// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    // RV32I funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load extract/extend, store merge, request legality.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      chk_funct3,
    input  logic [1:0]      chk_addr,
    input  logic            chk_we,
    output logic            chk_err,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] st_data
);

    logic       illegal;
    logic       misal;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    // Misaligned access or funct3 not defined for this direction
    always_comb begin
        illegal = 1'b0;
        misal   = 1'b0;
        if (chk_we) begin
            illegal = (chk_funct3 > F3_W);
        end else begin
            illegal = (chk_funct3 == 3'd3) || (chk_funct3 == 3'd6) || (chk_funct3 == 3'd7);
        end
        case (chk_funct3)
            F3_H, F3_HU: misal = chk_addr[0];
            F3_W:        misal = |chk_addr;
            default:     misal = 1'b0;
        endcase
        chk_err = illegal | misal;
    end

    // Select the addressed lane and extend it to a full word
    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'd0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'd0, half_sel};
            F3_W:    ld_data = word;
            default: ld_data = '0;
        endcase
    end

    // Overlay the store lane onto the old word; SW takes wdata whole
    always_comb begin
        st_data = word;
        case (funct3)
            F3_B: st_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (addr_lo[1]) begin
                    st_data[31:16] = wdata[15:0];
                end else begin
                    st_data[15:0] = wdata[15:0];
                end
            end
            default: st_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit with read-modify-write for sub-word stores to a word-only memory.
module lsu_rmw
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            req_err;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] st_data;

    lsu_align u_align (
        .chk_funct3 (req_funct3),
        .chk_addr   (req_addr[1:0]),
        .chk_we     (req_we),
        .chk_err    (req_err),
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .word       (mem_rd),
        .wdata      (wdata_q),
        .ld_data    (ld_data),
        .st_data    (st_data)
    );

    // Next state; wdata_q is reused to hold the merged word after the RMW read
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    wdata_d = st_data;
                    state_d = WR;
                end else begin
                    rdata_d = ld_data;
                    state_d = RESP;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs decoded from state and registers
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_we     = (state_q == WR);
    assign mem_a      = ((state_q == RD) || (state_q == WR)) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_wd     = (state_q == WR) ? wdata_q : '0;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: schedule-based reference model plus directed literal checks.
module tb_lsu_rmw;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] tb_mem  [64];
    logic [31:0] ref_mem [64];
    logic        preload;

    // per-cycle expectations, keyed by cycle number
    bit          s_busy [int];
    bit          s_rv   [int];
    bit          s_we   [int];
    bit          s_err  [int];
    logic [31:0] s_a    [int];
    logic [31:0] s_wd   [int];
    logic [31:0] s_rd   [int];

    int          acc_cyc = 0;
    int          nacc    = 0;
    int          nresp   = 0;
    int          nwe     = 0;
    int          obs_cyc = 0;
    int          obs_wcyc = 0;
    logic [31:0] obs_rd  = '0;
    logic [31:0] obs_wa  = '0;
    logic [31:0] obs_wd  = '0;
    logic        obs_err = 1'b0;

    lsu_rmw dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // environment memory: asynchronous read, synchronous write
    assign mem_rd = tb_mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= (i == 4) ? 32'h8899AABB : 32'h0;
        end else if (mem_we) begin
            tb_mem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic bad_f3;
        logic mis;
        if (we) bad_f3 = (f3 > 3'd2);
        else    bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
        return bad_f3 || mis;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int          sb;
        int          shh;
        logic [31:0] b;
        logic [31:0] h;
        sb  = 8 * int'(a[1:0]);
        shh = a[1] ? 16 : 0;
        b   = (w >> sb) & 32'hFF;
        h   = (w >> shh) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'd5:    return h;
            3'd2:    return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] old, input logic [31:0] wd);
        int sh;
        if (f3 == 3'd0) begin
            sh = 8 * int'(a[1:0]);
            return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else if (f3 == 3'd1) begin
            sh = a[1] ? 16 : 0;
            return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    function automatic void sched(input int c, input bit rv, input logic [31:0] rd, input bit err,
                                  input bit we, input logic [31:0] a, input logic [31:0] wd);
        s_busy[c] = 1'b1;
        s_rv[c]   = rv;
        s_rd[c]   = rd;
        s_err[c]  = err;
        s_we[c]   = we;
        s_a[c]    = a;
        s_wd[c]   = wd;
    endfunction

    // build the whole expected timeline of a request accepted at the end of cycle n
    function automatic void model_accept(input int n);
        logic [31:0] wa;
        logic [31:0] old;
        wa  = req_addr & 32'hFFFFFFFC;
        old = ref_mem[req_addr[7:2]];
        acc_cyc = n;
        nacc++;
        if (model_err(req_we, req_funct3, req_addr)) begin
            sched(n + 1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        end else if (!req_we) begin
            sched(n + 1, 1'b0, 32'h0, 1'b0, 1'b0, wa, 32'h0);
            sched(n + 2, 1'b1, model_load(req_funct3, req_addr, old), 1'b0, 1'b0, 32'h0, 32'h0);
        end else if (req_funct3 == 3'd2) begin
            sched(n + 1, 1'b0, 32'h0, 1'b0, 1'b1, wa, req_wdata);
            sched(n + 2, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        end else begin
            sched(n + 1, 1'b0, 32'h0, 1'b0, 1'b0, wa, 32'h0);
            sched(n + 2, 1'b0, 32'h0, 1'b0, 1'b1, wa, model_merge(req_funct3, req_addr, old, req_wdata));
            sched(n + 3, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endfunction

    // compare DUT outputs with the model every cycle, mid-cycle
    always @(negedge clk) begin
        bit          busy;
        bit          e_rv;
        bit          e_we;
        bit          e_err;
        logic [31:0] e_a;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        if (preload) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = (i == 4) ? 32'h8899AABB : 32'h0;
        end
        if (reset) begin
            for (int c = cyc; c < cyc + 5; c++) begin
                if (s_busy.exists(c)) begin
                    s_busy.delete(c); s_rv.delete(c); s_we.delete(c); s_err.delete(c);
                    s_a.delete(c); s_wd.delete(c); s_rd.delete(c);
                end
            end
        end
        busy = !reset && s_busy.exists(cyc);
        e_rv = 1'b0; e_we = 1'b0; e_err = 1'b0; e_a = '0; e_wd = '0; e_rd = '0;
        if (busy) begin
            e_rv = s_rv[cyc]; e_we = s_we[cyc]; e_err = s_err[cyc];
            e_a = s_a[cyc]; e_wd = s_wd[cyc]; e_rd = s_rd[cyc];
        end
        chk32("req_ready", 32'(req_ready), 32'(!busy));
        chk32("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk32("mem_we", 32'(mem_we), 32'(e_we));
        chk32("mem_a", mem_a, e_a);
        chk32("mem_wd", mem_wd, e_wd);
        if (e_rv || reset) begin
            chk32("resp_rdata", resp_rdata, e_rd);
            chk32("resp_err", 32'(resp_err), 32'(e_err));
        end
        if (resp_valid) begin
            nresp++;
            obs_cyc = cyc;
            obs_rd  = resp_rdata;
            obs_err = resp_err;
        end
        if (mem_we) begin
            nwe++;
            obs_wcyc = cyc;
            obs_wa   = mem_a;
            obs_wd   = mem_wd;
        end
        if (busy && e_we) ref_mem[e_a[7:2]] = e_wd;
        if (!reset && !busy && req_valid) model_accept(cyc);
    end

    // hold the request until an accept edge, returning just after that edge
    task automatic wait_accept();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready && !reset) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        wait_accept();
        req_valid  = 1'b0;
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic load_case(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        drain();
        chk32(name, obs_rd, exp);
        chk32({name, "_err"}, 32'(obs_err), 32'h0);
        chk32({name, "_lat"}, 32'(obs_cyc - acc_cyc), 32'd2);
    endtask

    task automatic err_case(input string name, input logic we, input logic [2:0] f3, input logic [31:0] a);
        int we0;
        we0 = nwe;
        issue(we, f3, a, 32'hFFFFFFFF);
        drain();
        chk32({name, "_err"}, 32'(obs_err), 32'h1);
        chk32({name, "_rdata"}, obs_rd, 32'h0);
        chk32({name, "_lat"}, 32'(obs_cyc - acc_cyc), 32'd1);
        chk32({name, "_nowe"}, 32'(nwe - we0), 32'd0);
    endtask

    initial begin
        int a1;
        int a2;
        int r0;
        int n0;
        int w0;
        reset      = 1'b1;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;

        @(negedge clk);
        chk32("rst_ready", 32'(req_ready), 32'h1);
        chk32("rst_mem_a", mem_a, 32'h0);
        chk32("rst_rdata", resp_rdata, 32'h0);
        @(posedge clk);
        #1;
        preload = 1'b0;
        reset   = 1'b0;
        drain();

        // sub-word and word loads from 0x8899AABB at 0x10
        load_case("LB_13",  3'd0, 32'h13, 32'hFFFFFF88);
        load_case("LBU_13", 3'd4, 32'h13, 32'h00000088);
        load_case("LH_12",  3'd1, 32'h12, 32'hFFFF8899);
        load_case("LHU_10", 3'd5, 32'h10, 32'h0000AABB);
        load_case("LW_10",  3'd2, 32'h10, 32'h8899AABB);

        // byte store via read-modify-write
        issue(1'b1, 3'd0, 32'h11, 32'h000000CC);
        drain();
        chk32("SB_wlat", 32'(obs_wcyc - acc_cyc), 32'd2);
        chk32("SB_wa", obs_wa, 32'h10);
        chk32("SB_wd", obs_wd, 32'h8899CCBB);
        chk32("SB_lat", 32'(obs_cyc - acc_cyc), 32'd3);
        load_case("LW_10_after_SB", 3'd2, 32'h10, 32'h8899CCBB);

        // full-word store
        issue(1'b1, 3'd2, 32'h20, 32'hDEADBEEF);
        drain();
        chk32("SW_wlat", 32'(obs_wcyc - acc_cyc), 32'd1);
        chk32("SW_wd", obs_wd, 32'hDEADBEEF);
        chk32("SW_lat", 32'(obs_cyc - acc_cyc), 32'd2);
        load_case("LW_20", 3'd2, 32'h20, 32'hDEADBEEF);

        // rejected requests
        err_case("SH_13",  1'b1, 3'd1, 32'h13);
        err_case("LW_12",  1'b0, 3'd2, 32'h12);
        err_case("LD_F3_3", 1'b0, 3'd3, 32'h10);

        // back-to-back loads with req_valid held high
        r0 = nresp;
        n0 = nacc;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h10;
        req_valid  = 1'b1;
        wait_accept();
        a1 = acc_cyc;
        req_addr = 32'h20;
        wait_accept();
        a2 = acc_cyc;
        req_valid = 1'b0;
        drain();
        chk32("b2b_spacing", 32'(a2 - a1), 32'd3);
        chk32("b2b_nresp", 32'(nresp - r0), 32'd2);
        chk32("b2b_nacc", 32'(nacc - n0), 32'd2);
        chk32("b2b_last", obs_rd, 32'hDEADBEEF);

        // reset during the read phase of a byte store
        r0 = nresp;
        w0 = nwe;
        issue(1'b1, 3'd0, 32'h11, 32'h00000055);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk32("post_rst_ready", 32'(req_ready), 32'h1);
        drain();
        chk32("abort_nresp", 32'(nresp - r0), 32'd0);
        chk32("abort_nwe", 32'(nwe - w0), 32'd0);
        chk32("abort_mem", tb_mem[4], 32'h8899CCBB);
        load_case("LW_10_after_abort", 3'd2, 32'h10, 32'h8899CCBB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
